ps2_key_sequencer: RTL

PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

---
 rtl/ps2_key_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: turns a stream of PS/2 scancode bytes into WASD key
// press/release events queued in a small FIFO. It also tracks which of the
// four keys are currently held.
// Build option: define PS2_TYPEMATIC_EN to queue every make byte, so that
// auto-repeats while a key is held are also queued. Without it, a make for a
// key that is already held is ignored.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no prefix pending; next plain byte is a make code
// BRK     | 0xF0 seen; next plain byte is a break code
// EXT     | 0xE0 seen; next plain byte is an extended make (dropped)
// EXT_BRK | 0xE0 and 0xF0 seen; next plain byte is an extended break (dropped)
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scanValid,
    input  logic [7:0] scanCode,
    output logic       evtValid,
    input  logic       evtReady,
    output logic [7:0] evtCode,
    output logic       evtRelease,
    output logic [3:0] keyHeld,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} decState;

    decState          state;
    decState          stateNext;
    logic             evtFound;
    logic             evtIsBreak;
    logic [3:0]       keyOneHot;
    logic             qualified;
    logic             alreadyHeld;
    logic             pushReq;
    logic             pushOk;
    logic             pop;
    logic             full;
    logic [8:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic [8:0]       head;

    // Decoder state register; only valid bytes move it.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Prefix tracking and detection of plain (non-prefix) make/break bytes.
    always_comb begin
        stateNext  = state;
        evtFound   = 1'b0;
        evtIsBreak = 1'b0;
        if (scanValid) begin
            case (state)
                IDLE: begin
                    if (scanCode == 8'hF0)      stateNext = BRK;
                    else if (scanCode == 8'hE0) stateNext = EXT;
                    else                        evtFound  = 1'b1;
                end
                BRK: begin
                    if (scanCode == 8'hE0) stateNext = EXT_BRK;
                    else if (scanCode != 8'hF0) begin
                        evtFound   = 1'b1;
                        evtIsBreak = 1'b1;
                        stateNext  = IDLE;
                    end
                end
                EXT: begin
                    if (scanCode == 8'hF0)      stateNext = EXT_BRK;
                    else if (scanCode != 8'hE0) stateNext = IDLE;
                end
                EXT_BRK: begin
                    if (scanCode != 8'hF0 && scanCode != 8'hE0) stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Map the four tracked scancodes onto keyHeld bit positions (W A S D).
    always_comb begin
        keyOneHot = 4'b0000;
        case (scanCode)
            8'h1D:   keyOneHot = 4'b1000;
            8'h1C:   keyOneHot = 4'b0100;
            8'h1B:   keyOneHot = 4'b0010;
            8'h23:   keyOneHot = 4'b0001;
            default: keyOneHot = 4'b0000;
        endcase
    end

    assign qualified   = evtFound && (keyOneHot != 4'b0000);
    assign alreadyHeld = (keyHeld & keyOneHot) != 4'b0000;
`ifdef PS2_TYPEMATIC_EN
    assign pushReq = qualified;
`else
    assign pushReq = qualified && (evtIsBreak || !alreadyHeld);
`endif

    assign full     = (count == FULL_CNT);
    assign evtValid = (count != '0);
    assign pop      = evtValid && evtReady;
    assign pushOk   = pushReq && (!full || pop);
    assign head     = fifoMem[rdPtr];

    // Outputs come from stored entries; zeroed while the queue is empty.
    assign evtCode    = evtValid ? head[7:0] : 8'h00;
    assign evtRelease = evtValid ? head[8]   : 1'b0;

    // Held-key bitmap follows qualified events even when the FIFO drops them.
    always_ff @(posedge clock) begin
        if (reset) begin
            keyHeld <= 4'b0000;
        end else if (qualified) begin
            if (evtIsBreak) keyHeld <= keyHeld & ~keyOneHot;
            else            keyHeld <= keyHeld | keyOneHot;
        end
    end

    // Event FIFO: pointers wrap naturally, count separates full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                fifoMem[wrPtr] <= {evtIsBreak, scanCode};
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
            case ({pushOk, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for events lost to a full queue.
    always_ff @(posedge clock) begin
        if (reset)                         overflow <= 1'b0;
        else if (pushReq && full && !pop)  overflow <= 1'b1;
    end

endmodule
